// File: rtl/page_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : page_loader_pkg
// Description : Shared state encoding, sizing constants and address helper
//               for the page loader.
// Revision    : 1.0  initial release
// ============================================================================
package page_loader_pkg;

    localparam int c_WORDS          = 16;
    localparam int c_BYTE_W         = 8;
    localparam int c_WORD_W         = 32;
    localparam int c_BYTES_PER_WORD = c_WORD_W / c_BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RUN     = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_SEND    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Word index to byte address; upper bits stay zero by construction.
    function automatic logic [c_WORD_W-1:0] word_address(input logic [c_WORD_W-1:0] index);
        return {index[c_WORD_W-3:0], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/page_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : page_loader_if
// Description : Host byte streams, bus master port and core control bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface page_loader_if;
    import page_loader_pkg::*;

    logic [c_BYTE_W-1:0] rx_data;
    logic                rx_valid;
    logic [c_BYTE_W-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                read;
    logic                write;
    logic [c_WORD_W-1:0] address;
    logic [c_WORD_W-1:0] write_data;
    logic [c_WORD_W-1:0] read_data;
    logic                option;
    logic [c_BYTE_W-1:0] memory_page_number;
    logic                core_reset;
    logic                finish;
    logic                busy;
    logic                done;

    modport master (
        input  rx_data, rx_valid, tx_ready, read_data, finish,
        output tx_data, tx_valid, read, write, address, write_data,
               option, memory_page_number, core_reset, busy, done
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, read_data, finish,
        input  tx_data, tx_valid, read, write, address, write_data,
               option, memory_page_number, core_reset, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/page_loader_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : page_loader_tx_serializer
// Description : Shifts a captured 32-bit word out as four bytes, LSB first,
//               over a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module page_loader_tx_serializer
    import page_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [c_WORD_W-1:0] word,
    input  logic                tx_ready,
    output logic [c_BYTE_W-1:0] tx_data,
    output logic                tx_valid,
    output logic                word_done
);

    logic [c_WORD_W-1:0] r_shift;
    logic [1:0]          r_cnt;
    logic                r_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift  <= '0;
            r_cnt    <= 2'd0;
            r_active <= 1'b0;
        end else if (load) begin
            r_shift  <= word;
            r_cnt    <= 2'd0;
            r_active <= 1'b1;
        end else if (r_active && tx_ready) begin
            r_shift <= {{c_BYTE_W{1'b0}}, r_shift[c_WORD_W-1:c_BYTE_W]};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_active <= 1'b0;
            end
        end
    end

    assign tx_valid  = r_active;
    assign tx_data   = r_shift[c_BYTE_W-1:0];
    assign word_done = r_active && tx_ready && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/page_loader.sv
`default_nettype none
// ============================================================================
// Module      : page_loader
// Description : Loads a memory page from the host byte stream, runs the core,
//               then streams the page back. Optional run watchdog under
//               PAGE_LOADER_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module page_loader
    import page_loader_pkg::*;
#(
    parameter int WORDS = c_WORDS
`ifdef PAGE_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic          clk,
    input  logic          reset,
`ifdef PAGE_LOADER_TIMEOUT_EN
    output logic          timeout,
`endif
    page_loader_if.master bus
);

    localparam int                 c_IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_IDX_W-1:0]   r_index;
    logic [1:0]           r_byte_cnt;
    logic [c_WORD_W-1:0]  r_word;
    logic [c_BYTE_W-1:0]  r_page;
    logic                 r_run_armed;
    logic                 w_expire;
    logic                 w_stop;
    logic                 w_word_done;
    logic                 w_last;

`ifdef PAGE_LOADER_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMR_W-1:0] r_timer;
    logic               r_timeout;

    assign w_expire = (r_state == S_RUN) && (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    assign w_last = (r_index == c_LAST_IDX);
    // The first RUN cycle ignores finish: the bus flag is still leaving reset.
    assign w_stop = (r_state == S_RUN) && ((r_run_armed && bus.finish) || w_expire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.rx_valid) w_next = S_LOAD;
            S_LOAD:         if (bus.rx_valid && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
            S_WRITE:        w_next = w_last ? S_RUN : S_LOAD;
            S_RUN:          if (w_stop) w_next = S_RD_REQ;
            S_RD_REQ:       w_next = S_RD_WAIT;
            S_RD_WAIT:      w_next = S_SEND;
            S_SEND:         if (w_word_done) w_next = w_last ? S_DONE : S_RD_REQ;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index     <= '0;
            r_byte_cnt  <= 2'd0;
            r_word      <= '0;
            r_page      <= '0;
            r_run_armed <= 1'b0;
`ifdef PAGE_LOADER_TIMEOUT_EN
            r_timer     <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.rx_valid) begin
                        r_page     <= bus.rx_data;
                        r_index    <= '0;
                        r_byte_cnt <= 2'd0;
`ifdef PAGE_LOADER_TIMEOUT_EN
                        r_timeout  <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (bus.rx_valid) begin
                        r_word[{r_byte_cnt, 3'b000} +: c_BYTE_W] <= bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_index     <= r_index + c_IDX_W'(1);
                    r_run_armed <= 1'b0;
`ifdef PAGE_LOADER_TIMEOUT_EN
                    r_timer     <= '0;
`endif
                end
                S_RUN: begin
                    r_run_armed <= 1'b1;
`ifdef PAGE_LOADER_TIMEOUT_EN
                    r_timer     <= r_timer + c_TMR_W'(1);
                    if (w_expire) begin
                        r_timeout <= 1'b1;
                    end
`endif
                    if (w_stop) begin
                        r_index <= '0;
                    end
                end
                S_SEND: begin
                    if (w_word_done) begin
                        r_index <= r_index + c_IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    page_loader_tx_serializer u_tx_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (r_state == S_RD_WAIT),
        .word      (bus.read_data),
        .tx_ready  (bus.tx_ready),
        .tx_data   (bus.tx_data),
        .tx_valid  (bus.tx_valid),
        .word_done (w_word_done)
    );

    // Bus strobes decode directly from state, so read/write/option are exclusive.
    assign bus.write              = (r_state == S_WRITE);
    assign bus.read               = (r_state == S_RD_REQ);
    assign bus.address            = word_address(c_WORD_W'(r_index));
    assign bus.write_data         = r_word;
    assign bus.option             = (r_state == S_RUN);
    assign bus.core_reset         = (r_state != S_RUN);
    assign bus.memory_page_number = r_page;
    assign bus.busy               = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done               = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_page_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_loader
// Description : Scoreboard bench for page_loader: load, run, readback, stall,
//               mid-readback reset and (with PAGE_LOADER_TIMEOUT_EN) watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module tb_page_loader;
    import page_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    page_loader_if bus();

    always #5 clk = ~clk;

`ifdef PAGE_LOADER_TIMEOUT_EN
    logic timeout;
    page_loader #(.WORDS(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .timeout(timeout), .bus(bus)
    );
`else
    page_loader #(.WORDS(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int rd_acc   = 0;
    int tx_acc   = 0;
    int stall_checks = 0;
    int stall_base   = 0;
    bit stall_en     = 1'b0;

    logic [63:0] wq[$];
    logic [31:0] rq[$];
    logic [7:0]  tq[$];
    logic [31:0] mem [16];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Slave memory: write lands on the edge, read data valid the next cycle.
    always @(posedge clk) begin
        if (bus.write) mem[bus.address[5:2]] <= bus.write_data;
        if (bus.read)  bus.read_data <= mem[bus.address[5:2]];
    end

    // Output monitor: pops expectations as the DUT produces results.
    initial begin
        logic [63:0] e;
        logic [7:0]  held;
        bit          stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.write) begin
                    check_value("wr_option", bus.option, 0);
                    check_value("wr_rd_excl", bus.read, 0);
                    if (wq.size() == 0) check_value("wr_unexpected", bus.write, 0);
                    else begin
                        e = wq.pop_front();
                        check_value("wr_addr", bus.address, e[63:32]);
                        check_value("wr_data", bus.write_data, e[31:0]);
                    end
                end
                if (bus.read) begin
                    rd_acc++;
                    check_value("rd_option", bus.option, 0);
                    if (rq.size() == 0) check_value("rd_unexpected", bus.read, 0);
                    else check_value("rd_addr", bus.address, rq.pop_front());
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    tx_acc++;
                    stalled = 1'b0;
                    if (tq.size() == 0) check_value("tx_unexpected", bus.tx_valid, 0);
                    else check_value("tx_byte", 32'(bus.tx_data), 32'(tq.pop_front()));
                end else if (bus.tx_valid) begin
                    if (stalled) begin
                        stall_checks++;
                        check_value("tx_hold", 32'(bus.tx_data), 32'(held));
                    end
                    stalled = 1'b1;
                    held    = bus.tx_data;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Transmitter: one five-cycle back-pressure window on byte 2 when armed.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            if (stall_en && (tx_acc == stall_base + 2)) begin
                #1 bus.tx_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.tx_ready = 1'b1;
                stall_en = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic load_page(input logic [7:0] page, input bit rnd);
        logic [7:0]  b;
        logic [31:0] w;
        send_byte(page);
        for (int i = 0; i < 16; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                b = rnd ? 8'($urandom) : 8'(4 * i + k);
                w[8*k +: 8] = b;
                tq.push_back(b);
                send_byte(b);
            end
            wq.push_back({32'(4 * i), w});
        end
    endtask

    task automatic wait_run(input logic [7:0] page);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.option && n < 2000);
        check_value("run_entry", bus.option, 1);
        check_value("run_core_reset", bus.core_reset, 0);
        check_value("page", 32'(bus.memory_page_number), 32'(page));
        check_value("wq_drained", wq.size(), 0);
    endtask

    // Call just after a rising edge; finish is sampled on the next one.
    task automatic raise_finish();
        bus.finish = 1'b1;
        for (int i = 0; i < 16; i++) rq.push_back(32'(4 * i));
        @(negedge clk);
        check_value("finish_pre_option", bus.option, 1);
        @(negedge clk);
        check_value("finish_option", bus.option, 0);
        check_value("finish_core_reset", bus.core_reset, 1);
        check_value("finish_busy", bus.busy, 1);
        bus.finish = 1'b0;
    endtask

    task automatic wait_done(input int tx_start);
        int n;
        n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_value("done", bus.done, 1);
        check_value("done_busy", bus.busy, 0);
        check_value("tx_count", tx_acc - tx_start, 64);
        check_value("tq_drained", tq.size(), 0);
        check_value("rq_drained", rq.size(), 0);
    endtask

    initial begin
        int n;
        int t0;
        int r0;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.finish   = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst_tx_valid", bus.tx_valid, 0);
        check_value("rst_option", bus.option, 0);
        check_value("rst_core_reset", bus.core_reset, 1);
        check_value("rst_busy_done", {bus.busy, bus.done}, 0);
        check_value("rst_rd_wr", {bus.read, bus.write}, 0);
        check_value("rst_address", bus.address, 0);
        check_value("rst_write_data", bus.write_data, 0);
        check_value("rst_page", 32'(bus.memory_page_number), 0);
        check_value("rst_tx_data", 32'(bus.tx_data), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Session 1: incrementing page, rx noise during RUN, stalled readback.
        load_page(8'h03, 1'b0);
        wait_run(8'h03);
        check_value("mem_word0", mem[0], 32'h0302_0100);
        check_value("mem_word15", mem[15], 32'h3F3E_3D3C);
        repeat (3) begin
            @(posedge clk);
            #1 bus.rx_data = 8'hEE;
            bus.rx_valid = 1'b1;
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        repeat (5) @(posedge clk);
        check_value("rx_ignored_in_run", bus.option, 1);
        t0 = tx_acc;
        stall_base = tx_acc;
        stall_en = 1'b1;
        #1 raise_finish();
        wait_done(t0);
        check_value("stall_seen", stall_checks, 4);

        // Session 2: random page, reset during readback of word 7.
        load_page(8'h05, 1'b1);
        wait_run(8'h05);
        @(posedge clk);
        #1 r0 = rd_acc;
        raise_finish();
        n = 0;
        while (!((rd_acc - r0) == 8 && bus.tx_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_value("reached_word7", rd_acc - r0, 8);
        check_value("word7_sending", bus.tx_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check_value("midrst_tx_valid", bus.tx_valid, 0);
        check_value("midrst_option", bus.option, 0);
        check_value("midrst_core_reset", bus.core_reset, 1);
        check_value("midrst_idle", {bus.busy, bus.done}, 0);
        check_value("midrst_page", 32'(bus.memory_page_number), 0);
        tq.delete();
        rq.delete();
        wq.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check_value("postrst_tx_valid", bus.tx_valid, 0);
        check_value("postrst_busy", bus.busy, 0);

        // Session 3: finish during the first RUN cycle must be ignored.
        load_page(8'h07, 1'b1);
        wait_run(8'h07);
        bus.finish = 1'b1;
        @(posedge clk);
        #1 bus.finish = 1'b0;
        @(negedge clk);
        check_value("finish_first_ignored", bus.option, 1);
        t0 = tx_acc;
        @(posedge clk);
        #1 raise_finish();
        wait_done(t0);

`ifdef PAGE_LOADER_TIMEOUT_EN
        // Session 4: no finish; the watchdog ends RUN after 100 cycles.
        load_page(8'h09, 1'b1);
        wait_run(8'h09);
        check_value("timeout_clear", timeout, 0);
        for (int i = 0; i < 16; i++) rq.push_back(32'(4 * i));
        t0 = tx_acc;
        n = 1;
        while (bus.option && n < 1000) begin
            @(negedge clk);
            if (bus.option) n++;
        end
        check_value("timeout_run_len", n, 100);
        check_value("timeout_flag", timeout, 1);
        check_value("timeout_core_reset", bus.core_reset, 1);
        wait_done(t0);
        check_value("timeout_sticky", timeout, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
